// File: rtl/sha224_hex_streamer.sv
// Converts SHA-224 digests into an ASCII hex byte stream with valid/ready handshake.
// Two-entry digest buffer; all outputs are registered from next-state logic.
module sha224_hex_streamer #(
  parameter int LF_EN = 1,
  parameter int UPPER = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         ivalid,
  input  logic [31:0]  iid,
  input  logic [223:0] isha,
  output logic         ovalid,
  input  logic         oready,
  output logic         olast,
  output logic [31:0]  oid,
  output logic [7:0]   odata,
  output logic         ovf,
  output logic [15:0]  drop_cnt
);

  localparam logic [5:0] LAST_IDX = (LF_EN != 0) ? 6'd56 : 6'd55;

  logic [255:0] mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic [5:0]   idx_r;
  logic         ovalid_r;
  logic         olast_r;
  logic [31:0]  oid_r;
  logic [7:0]   odata_r;
  logic         ovf_r;
  logic [15:0]  drop_cnt_r;

  logic         xfer_s;
  logic         last_s;
  logic         full_s;
  logic         push_s;
  logic         drop_s;
  logic [5:0]   idx_nxt_s;
  logic [255:0] mem_nxt_s [2];
  logic         wr_ptr_nxt_s;
  logic         rd_ptr_nxt_s;
  logic [1:0]   count_nxt_s;
  logic [255:0] head_nxt_s;
  logic         ovalid_nxt_s;
  logic         olast_nxt_s;
  logic [31:0]  oid_nxt_s;
  logic [7:0]   odata_nxt_s;
  logic [15:0]  drop_cnt_nxt_s;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) begin
      c = 8'h30 + {4'h0, nib};
    end else if (UPPER != 0) begin
      c = 8'h37 + {4'h0, nib};
    end else begin
      c = 8'h57 + {4'h0, nib};
    end
    return c;
  endfunction

  // Index 56 only exists with the line feed enabled, so anything past 55 is LF.
  function automatic logic [7:0] frame_byte(input logic [223:0] sha, input logic [5:0] n);
    logic [223:0] sh;
    logic [7:0]   c;
    sh = sha << {n, 2'b00};
    if (n > 6'd55) begin
      c = 8'h0A;
    end else begin
      c = hex_ascii(sh[223:220]);
    end
    return c;
  endfunction

  // Handshake, buffer bookkeeping and next-cycle output values.
  always_comb begin
    xfer_s       = (count_r != 2'd0) && oready;
    last_s       = xfer_s && (idx_r == LAST_IDX);
    full_s       = (count_r == 2'd2);
    // A pop on the final byte frees a slot for a same-cycle write.
    push_s       = ivalid && (!full_s || last_s);
    drop_s       = ivalid && full_s && !last_s;

    if (last_s) begin
      idx_nxt_s = 6'd0;
    end else if (xfer_s) begin
      idx_nxt_s = idx_r + 6'd1;
    end else begin
      idx_nxt_s = idx_r;
    end

    mem_nxt_s[0] = mem_r[0];
    mem_nxt_s[1] = mem_r[1];
    if (push_s) begin
      mem_nxt_s[wr_ptr_r] = {iid, isha};
    end else begin
      mem_nxt_s[wr_ptr_r] = mem_r[wr_ptr_r];
    end

    wr_ptr_nxt_s = wr_ptr_r ^ push_s;
    rd_ptr_nxt_s = rd_ptr_r ^ last_s;
    count_nxt_s  = count_r + {1'b0, push_s} - {1'b0, last_s};
    head_nxt_s   = mem_nxt_s[rd_ptr_nxt_s];
    ovalid_nxt_s = (count_nxt_s != 2'd0);

    if (ovalid_nxt_s) begin
      odata_nxt_s = frame_byte(head_nxt_s[223:0], idx_nxt_s);
      olast_nxt_s = (idx_nxt_s == LAST_IDX);
      oid_nxt_s   = head_nxt_s[255:224];
    end else begin
      odata_nxt_s = 8'h00;
      olast_nxt_s = 1'b0;
      oid_nxt_s   = 32'd0;
    end

    if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_nxt_s = drop_cnt_r + 16'd1;
    end else begin
      drop_cnt_nxt_s = drop_cnt_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_r[0]   <= 256'd0;
      mem_r[1]   <= 256'd0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      idx_r      <= 6'd0;
      ovalid_r   <= 1'b0;
      olast_r    <= 1'b0;
      oid_r      <= 32'd0;
      odata_r    <= 8'h00;
      ovf_r      <= 1'b0;
      drop_cnt_r <= 16'd0;
    end else begin
      mem_r[0]   <= mem_nxt_s[0];
      mem_r[1]   <= mem_nxt_s[1];
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      idx_r      <= idx_nxt_s;
      ovalid_r   <= ovalid_nxt_s;
      olast_r    <= olast_nxt_s;
      oid_r      <= oid_nxt_s;
      odata_r    <= odata_nxt_s;
      ovf_r      <= drop_s;
      drop_cnt_r <= drop_cnt_nxt_s;
    end
  end

  assign ovalid   = ovalid_r;
  assign olast    = olast_r;
  assign oid      = oid_r;
  assign odata    = odata_r;
  assign ovf      = ovf_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: doc/sha224_hex_streamer.md
SHA224_HEX_STREAMER -- requirements
Module: sha224_hex_streamer

Interface
REQ-001 SHALL have parameter LF_EN, default 1: append line-feed byte 8'h0A after each digest.
REQ-002 SHALL have parameter UPPER, default 0: 1 = hex letters 'A'-'F', 0 = 'a'-'f'.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ivalid  input  1  one-cycle digest strobe from the sha224 core; no ready back-pressure exists upstream.
REQ-006 SHALL have port iid  input  32  message id, qualified by ivalid.
REQ-007 SHALL have port isha  input  224  digest, qualified by ivalid; isha[223:220] is the first nibble.
REQ-008 SHALL have port ovalid  output  1  byte-stream valid.
REQ-009 SHALL have port oready  input  1  byte-stream ready from the sink.
REQ-010 SHALL have port olast  output  1  marks the final byte of a digest frame.
REQ-011 SHALL have port oid  output  32  id of the digest being streamed, constant across the frame.
REQ-012 SHALL have port odata  output  8  ASCII byte.
REQ-013 SHALL have port ovf  output  1  one-cycle pulse when an incoming digest is dropped.
REQ-014 SHALL have port drop_cnt  output  16  saturating count of dropped digests.

Function
REQ-015 SHALL buffer up to 2 {iid, isha} entries in a FIFO; an entry is written on ivalid when not full.
REQ-016 SHALL, on ivalid with FIFO full and no pop in the same cycle, discard the digest, pulse ovf for exactly the next cycle, and increment drop_cnt; drop_cnt saturates at 16'hFFFF.
REQ-017 SHALL, on ivalid with FIFO full and the head's final byte transferring in the same cycle, pop first then accept the write (no drop, no ovf).
REQ-018 SHALL drive ovalid high whenever the FIFO is non-empty; odata, olast and oid are derived from the head entry and a 6-bit byte index.
REQ-019 SHALL count the frame length as 56 hex bytes plus 1 LF byte when LF_EN=1, otherwise 56 bytes.
REQ-020 SHALL, for byte index n in 0..55, drive odata as the ASCII hex of isha[223-4n -: 4]: 0-9 maps to 8'h30-8'h39, 10-15 maps to 8'h61-8'h66 (8'h41-8'h46 when UPPER=1).
REQ-021 SHALL, for byte index n = 56 (LF_EN=1), drive odata = 8'h0A.
REQ-022 SHALL assert olast only on the last byte index of the frame.
REQ-023 SHALL count a transfer as ovalid && oready; each transfer increments the index, and the final transfer resets the index to 0 and pops the head.
REQ-024 SHALL hold odata, olast, oid and ovalid stable while ovalid && !oready.
REQ-025 SHALL drive odata = 8'h00, olast = 0 and oid = 0 when ovalid = 0.
REQ-026 SHALL give latency ivalid → ovalid of 1 cycle: ivalid sampled at edge k into an empty FIFO produces ovalid high after edge k.
REQ-027 SHALL have no combinational path from ivalid, iid, isha or oready to any output.
REQ-028 SHALL stream back-to-back frames without bubbles: the first byte of the next entry is valid in the cycle after the prior olast transfer.

Reset
REQ-029 SHALL, while rstn = 0 (asynchronously), force ovalid=0, olast=0, oid=0, odata=0, ovf=0, drop_cnt=0, FIFO empty and byte index 0.
REQ-030 SHALL, on reset mid-frame, discard the partial frame and all buffered entries; after release, output resumes only with a fresh ivalid, starting at index 0.

Verification
REQ-031 SHALL pass this scenario: iid=111 and isha=SHA-224("abc")=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7 with oready=1 → 57 bytes "23097d22…9da7\n" on consecutive cycles, olast only on 8'h0A, oid=111 throughout, first ovalid one cycle after ivalid.
REQ-032 SHALL pass this scenario: same digest with oready random (≈20% high) → identical byte sequence, and outputs never change while ovalid && !oready.
REQ-033 SHALL pass this scenario: oready=0 and ivalid on 3 consecutive cycles (ids 1, 2, 3) → ids 1 and 2 stored, id 3 dropped, a single ovf pulse, drop_cnt=1; after oready=1, frames stream in order 1 then 2.
REQ-034 SHALL pass this scenario: FIFO full and ivalid coincident with the olast transfer → no drop, ovf=0, all three frames streamed.
REQ-035 SHALL pass this scenario: UPPER=1, LF_EN=0, isha=224'h0…0ABCDEF → 56 bytes ending "ABCDEF" with olast on byte 56; byte count 56 exactly.
REQ-036 SHALL pass this scenario: rstn pulsed low at byte 20 of a frame with a second entry queued → all outputs 0 during reset, no output after release until the next ivalid, whose frame starts at the first character.
